// File: rtl/muldiv_alu_if.sv
// Handshake bundle between the control unit (master) and the iterative RV32M
// multiply/divide unit (slave).
interface muldiv_alu_if #(
  parameter int BITS = 32
);
  logic            En;
  logic            Flush;
  logic [4:0]      ALUCtrl;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic            MulDivAluReady;
  logic            Busy;
  logic [BITS-1:0] Result;

  modport master (
    output En, Flush, ALUCtrl, A, B,
    input  MulDivAluReady, Busy, Result
  );

  modport slave (
    input  En, Flush, ALUCtrl, A, B,
    output MulDivAluReady, Busy, Result
  );
endinterface

// File: rtl/muldiv_alu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, registered result, one-cycle ready.
// Define MULDIV_SINGLE_CYCLE_MUL_EN to compute multiplies combinationally via the IDLE fast path.
module muldiv_alu #(
  parameter int BITS = 32
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_alu_if.slave   bus
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [4:0] ALUCTRL_MUL    = 5'h10;
  localparam logic [4:0] ALUCTRL_MULH   = 5'h11;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'h12;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'h13;
  localparam logic [4:0] ALUCTRL_DIV    = 5'h14;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'h15;
  localparam logic [4:0] ALUCTRL_REM    = 5'h16;
  localparam logic [4:0] ALUCTRL_REMU   = 5'h17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [2*BITS-1:0] acc_q, acc_d;
  logic [BITS-1:0]   dvs_q, dvs_d;

  logic              recognised, a_signed, b_signed, a_neg, b_neg, div_zero, ovf;
  logic [BITS-1:0]   a_mag, b_mag;
  logic [BITS:0]     mul_sum, div_rem, div_sub;
  logic              div_ge;
  logic [2*BITS-1:0] mul_step, div_step, acc_step;

  function automatic logic [BITS-1:0] neg_w(input logic n, input logic [BITS-1:0] v);
    return n ? (~v + BITS'(1)) : v;
  endfunction

  function automatic logic [2*BITS-1:0] neg_2w(input logic n, input logic [2*BITS-1:0] v);
    return n ? (~v + (2*BITS)'(1)) : v;
  endfunction

  // Sign-correct the final accumulator and pick product half or quotient/remainder.
  function automatic logic [BITS-1:0] finalize(input logic [2:0] op, input logic n, input logic rn,
                                               input logic [2*BITS-1:0] acc);
    logic [2*BITS-1:0] prod;
    prod = neg_2w(n, acc);
    if (!op[2]) return (op[1:0] == 2'b00) ? prod[BITS-1:0] : prod[2*BITS-1:BITS];
    else        return op[1] ? neg_w(rn, acc[2*BITS-1:BITS]) : neg_w(n, acc[BITS-1:0]);
  endfunction

  always_comb begin
    recognised = (bus.ALUCtrl[4:3] == 2'b10);
    a_signed   = (bus.ALUCtrl == ALUCTRL_MUL) || (bus.ALUCtrl == ALUCTRL_MULH) ||
                 (bus.ALUCtrl == ALUCTRL_MULHSU) || (bus.ALUCtrl == ALUCTRL_DIV) ||
                 (bus.ALUCtrl == ALUCTRL_REM);
    b_signed   = (bus.ALUCtrl == ALUCTRL_MUL) || (bus.ALUCtrl == ALUCTRL_MULH) ||
                 (bus.ALUCtrl == ALUCTRL_DIV) || (bus.ALUCtrl == ALUCTRL_REM);
    a_neg      = a_signed && bus.A[BITS-1];
    b_neg      = b_signed && bus.B[BITS-1];
    a_mag      = neg_w(a_neg, bus.A);
    b_mag      = neg_w(b_neg, bus.B);
    div_zero   = (bus.B == '0);
    ovf        = ((bus.ALUCtrl == ALUCTRL_DIV) || (bus.ALUCtrl == ALUCTRL_REM)) &&
                 (bus.A == {1'b1, {(BITS-1){1'b0}}}) && (bus.B == '1);

    mul_sum  = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_step = {mul_sum, acc_q[BITS-1:1]};
    div_rem  = {acc_q[2*BITS-1:BITS], acc_q[BITS-1]};
    div_ge   = (div_rem >= {1'b0, dvs_q});
    div_sub  = div_ge ? (div_rem - {1'b0, dvs_q}) : div_rem;
    div_step = {div_sub[BITS-1:0], acc_q[BITS-2:0], div_ge};
    acc_step = op_q[2] ? div_step : mul_step;
  end

  always_comb begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic signed [2*BITS-1:0] ax, bx, prod;
`endif
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    ax       = {{BITS{a_signed & bus.A[BITS-1]}}, bus.A};
    bx       = {{BITS{b_signed & bus.B[BITS-1]}}, bus.B};
    prod     = ax * bx;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.En && !bus.Flush && recognised) begin
          op_d    = bus.ALUCtrl[2:0];
          acc_d   = {{BITS{1'b0}}, a_mag};
          dvs_d   = b_mag;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          cnt_d   = '0;
          state_d = BUSY;
          if (bus.ALUCtrl[2]) begin
            if (div_zero) begin
              result_d = bus.ALUCtrl[1] ? bus.A : '1;
              state_d  = DONE;
            end else if (ovf) begin
              result_d = bus.ALUCtrl[1] ? '0 : bus.A;
              state_d  = DONE;
            end
          end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
          else begin
            result_d = (bus.ALUCtrl[1:0] == 2'b00) ? prod[BITS-1:0] : prod[2*BITS-1:BITS];
            state_d  = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BITS-1)) begin
            result_d = finalize(op_q, neg_q, rneg_q, acc_step);
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    acc_q  <= acc_d;
    dvs_q  <= dvs_d;
  end

  assign bus.MulDivAluReady = (state_q == DONE);
  assign bus.Busy           = (state_q == BUSY);
  assign bus.Result         = result_q;
endmodule

// File: tb/tb_muldiv_alu.sv
// Directed-vector bench for muldiv_alu: latency, results, fast paths, flush, reset and restart.
module tb_muldiv_alu;
  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   last_busy;

  muldiv_alu_if #(.BITS(32)) bus ();
  muldiv_alu #(.BITS(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_n;
    @(negedge clk);
    bus.En = 1'b1; bus.ALUCtrl = ctrl; bus.A = a; bus.B = b;
    @(posedge clk);
    #1 bus.En = 1'b0; bus.ALUCtrl = OP_ADD;
    lat = -1;
    busy_n = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.Busy) busy_n++;
      if (bus.MulDivAluReady) lat = k;
    end
    last_busy = busy_n;
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.Result), 64'(exp_res));
  endtask

  initial begin
    int seen_rdy, seen_busy, r1, r2;
    logic [31:0] res1;
    rst_n = 1'b0;
    bus.En = 1'b0; bus.Flush = 1'b0; bus.ALUCtrl = OP_ADD; bus.A = '0; bus.B = '0;
    #3;
    chk("rst_result", 64'(bus.Result), 64'h0);
    chk("rst_ready", 64'(bus.MulDivAluReady), 64'h0);
    chk("rst_busy", 64'(bus.Busy), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    chk("mul_busy_cycles", 64'(last_busy), 64'(MUL_BUSY));
    run_op("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulh_ff", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
    run_op("mulhsu_ff", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    chk("div_busy_cycles", 64'(last_busy), 64'd32);
    run_op("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'h00000003, 33);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'h00000002, 33);

    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'h00000005, 1);

    // Flush a DIVU at T+10; Result must keep 5
    @(negedge clk);
    bus.En = 1'b1; bus.ALUCtrl = OP_DIVU; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.En = 1'b0; bus.ALUCtrl = OP_ADD;
    repeat (9) @(posedge clk);
    #1 bus.Flush = 1'b1;
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_t11", 64'(bus.Busy), 64'h0);
    seen_rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.MulDivAluReady) seen_rdy = 1;
    end
    chk("flush_no_ready", 64'(seen_rdy), 64'h0);
    chk("flush_result_kept", 64'(bus.Result), 64'h5);

    // Asynchronous reset at T+5 of a DIV
    @(negedge clk);
    bus.En = 1'b1; bus.ALUCtrl = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.En = 1'b0; bus.ALUCtrl = OP_ADD;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", 64'(bus.Result), 64'h0);
    chk("arst_busy", 64'(bus.Busy), 64'h0);
    chk("arst_ready", 64'(bus.MulDivAluReady), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div_after_rst", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);

    // Unrecognised op is ignored
    @(negedge clk);
    bus.En = 1'b1; bus.ALUCtrl = OP_ADD; bus.A = 32'd1; bus.B = 32'd2;
    seen_rdy = 0;
    seen_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.MulDivAluReady) seen_rdy = 1;
      if (bus.Busy) seen_busy = 1;
    end
    chk("add_no_busy", 64'(seen_busy), 64'h0);
    chk("add_no_ready", 64'(seen_rdy), 64'h0);

    // Back-to-back MULs with En held
    bus.ALUCtrl = OP_MUL; bus.A = 32'd3; bus.B = 32'd5;
    r1 = -1;
    r2 = -1;
    res1 = '0;
    for (int k = 1; k <= 90 && r2 < 0; k++) begin
      @(negedge clk);
      if (bus.MulDivAluReady) begin
        if (r1 < 0) begin
          r1 = k;
          res1 = bus.Result;
          bus.A = 32'd6; bus.B = 32'd7;
        end else begin
          r2 = k;
        end
      end
    end
    bus.En = 1'b0; bus.ALUCtrl = OP_ADD;
    chk("b2b_first_lat", 64'(r1), 64'(MUL_LAT));
    chk("b2b_first_res", 64'(res1), 64'd15);
    chk("b2b_gap", 64'(r2 - r1), 64'(MUL_LAT + 1));
    chk("b2b_second_res", 64'(bus.Result), 64'd42);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_alu.md
Name: muldiv_alu

Overview:
- Iterative RV32M multiply/divide unit; the consumer side of the control unit's `ALUCtrl` / `MulDivAluReady` stall handshake.
- The control unit holds the M-extension instruction and stalls while `MulDivAluReady` is low.
- This block latches the operands, iterates one bit per cycle, and returns a registered result with a one-cycle ready pulse that releases the stall and enables register write.
- Sits in the EX stage beside the single-cycle ALU.

Parameters:
- BITS, 32, operand/result width; the iteration count equals BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- En  input  1  EX stage holds a valid instruction.
- Flush  input  1  synchronous abort of any in-flight operation.
- ALUCtrl  input  5  operation code, encoded with the shared `ALUCTRL_*` definitions.
- A  input  BITS  rs1 operand.
- B  input  BITS  rs2 operand.
- MulDivAluReady  output  1  one-cycle pulse; Result valid this cycle.
- Busy  output  1  high in the BUSY state.
- Result  output  BITS  registered result; holds its value until the next completion.

Behaviour:
- Clocking and reset: one clock, clk; asynchronous active-low reset, rst_n. Reset (including mid-operation) forces state IDLE, counter 0, Result 0, MulDivAluReady 0, Busy 0.
- Recognised ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Any other ALUCtrl value is ignored: stay in IDLE, no ready pulse.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY: at cycle T, when En=1, Flush=0 and ALUCtrl is a recognised op.
  - Latch the op, the operand magnitudes and the result sign.
  - Signedness: A signed for MUL/MULH/MULHSU/DIV/REM; B signed for MUL/MULH/DIV/REM; unsigned otherwise.
- BUSY: BITS iterations, cycles T+1..T+BITS; counter counts 0..BITS-1.
  - Multiply: shift-add into a 2*BITS-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - A, B, ALUCtrl and En changes are ignored while BUSY.
  - On the last iteration, apply sign correction (two's-complement negate), select the low/high product half or quotient/remainder, and register Result. Go to DONE.
- DONE (cycle T+BITS+1): MulDivAluReady=1 for exactly one cycle; next state IDLE unconditionally.
- Normal latency: op presented at T -> ready at T+BITS+1 (T+33 at default).
- Upstream must advance or deassert En in the cycle after ready. An instruction still presented in IDLE restarts.
- Fast paths: IDLE -> DONE directly, ready at T+1, Result registered at the end of T.
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> A.
  - Signed overflow, DIV/REM with A = most-negative and B = -1: DIV -> A; REM -> 0.
- Sign rules: quotient negative iff operand signs differ and divisor non-zero; remainder takes the dividend's sign; product sign is the XOR of the signed operand signs.
- Flush: in BUSY or DONE -> IDLE next cycle, no ready pulse, Result unchanged. Flush in IDLE blocks a start that cycle. Flush has priority over completion.
- Busy = (state == BUSY).

Optional Feature:
- Macro: MULDIV_SINGLE_CYCLE_MUL_EN.
- Defined: multiply ops compute with a combinational BITS x BITS multiplier in IDLE and take the fast path (ready at T+1). Divide is unchanged.
- Undefined: all multiplies iterate, ready at T+BITS+1.
- Results are identical in both configurations.

Test Plan:
- MUL A=7, B=0xFFFFFFFD at T -> Busy T+1..T+32; ready at T+33 with Result=0xFFFFFFEB.
- A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- A=0xFFFFFFF9, B=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 7/2 -> 0x00000003.
- Fast paths, ready at T+1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Abort and restart:
  - Flush at T+10 of a DIVU -> IDLE at T+11, no ready, Result keeps its old value.
  - rst_n low at T+5 -> all outputs 0 immediately.
  - A new op afterwards takes the full 33 cycles.
- ALUCtrl=ADD with En=1 -> stays IDLE, Busy=0, no ready.
- Back-to-back MUL ops (En held, op changed after ready) -> two pulses 34 cycles apart.
